node_serdes: RTL

- Parametrised successor to the fixed 32-bit/8-bit network node; sits between the testbench-side packet interface and one router port.
- Outbound path: packets are queued in a DEPTH-entry FIFO, then serialised MSB-first into PHIT_W-bit phits using the free/put handshake.
- Inbound path: NPHITS consecutive phits are deserialised into one packet and presented with a one-cycle valid pulse.

---
 rtl/node_serdes_if.sv | 26 ++
 rtl/node_serdes.sv | 135 +++++++++++++
 2 files changed

// File: rtl/node_serdes_if.sv
// node_serdes_if: packet-side and router-side signals of one node_serdes.
// master is the environment (testbench/router), slave is the node itself.
interface node_serdes_if #(
    parameter int PKT_W  = 32,
    parameter int PHIT_W = 8
);
    logic [PKT_W-1:0]  pkt_in;
    logic              pkt_in_avail;
    logic              cQ_full;
    logic [PKT_W-1:0]  pkt_out;
    logic              pkt_out_avail;
    logic              free_outbound;
    logic              put_outbound;
    logic [PHIT_W-1:0] payload_outbound;
    logic              free_inbound;
    logic              put_inbound;
    logic [PHIT_W-1:0] payload_inbound;
    modport master (
        output pkt_in, pkt_in_avail, free_outbound, put_inbound, payload_inbound,
        input  cQ_full, pkt_out, pkt_out_avail, put_outbound, payload_outbound, free_inbound
    );
    modport slave (
        input  pkt_in, pkt_in_avail, free_outbound, put_inbound, payload_inbound,
        output cQ_full, pkt_out, pkt_out_avail, put_outbound, payload_outbound, free_inbound
    );
endinterface

// File: rtl/node_serdes.sv
// node_serdes: queued MSB-first packet serialiser and phit deserialiser for one router port.
// Define NODE_STATS_EN to add saturating tx/rx/drop packet counters.
module node_serdes #(
    parameter int PKT_W  = 32,
    parameter int PHIT_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic clk,
    input  logic rst_b,
    node_serdes_if.slave bus
`ifdef NODE_STATS_EN
    ,
    output logic [15:0] tx_pkt_cnt,
    output logic [15:0] rx_pkt_cnt,
    output logic [15:0] drop_cnt
`endif
);
    localparam int NPHITS = PKT_W / PHIT_W;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW = (NPHITS > 1) ? $clog2(NPHITS) : 1;

    if (PKT_W % PHIT_W != 0 || NPHITS < 2 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("node_serdes: invalid PKT_W/PHIT_W/DEPTH combination");
    end

    logic [PKT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count, count_n;
    logic             push, pop;
    assign push    = bus.pkt_in_avail && !bus.cQ_full;
    assign count_n = count + (AW+1)'(push) - (AW+1)'(pop);

    always_ff @(posedge clk or negedge rst_b)
        if (!rst_b) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            bus.cQ_full <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr + AW'(push);
            rd_ptr      <= rd_ptr + AW'(pop);
            count       <= count_n;
            bus.cQ_full <= count_n == (AW+1)'(DEPTH);
        end

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= bus.pkt_in;

    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
    tx_state_t         tx_state, tx_next;
    logic [IW-1:0]     tx_idx, tx_idx_n;
    logic              tx_last, put_n;
    logic [PHIT_W-1:0] payload_n;
    logic [PKT_W-1:0]  head;
    assign head    = mem[rd_ptr];
    assign tx_last = tx_state == TX_SEND && tx_idx == IW'(NPHITS - 1);
    assign pop     = tx_last;

    always_ff @(posedge clk or negedge rst_b)
        if (!rst_b) begin
            tx_state             <= TX_IDLE;
            tx_idx               <= '0;
            bus.put_outbound     <= 1'b0;
            bus.payload_outbound <= '0;
        end else begin
            tx_state             <= tx_next;
            tx_idx               <= tx_idx_n;
            bus.put_outbound     <= put_n;
            bus.payload_outbound <= payload_n;
        end

    always_comb
        tx_next = tx_state == TX_IDLE ? ((count != '0 && bus.free_outbound) ? TX_SEND : TX_IDLE)
                                      : (tx_last ? TX_IDLE : TX_SEND);

    // Outputs are registered, so the next phit is chosen from the next index.
    always_comb begin
        tx_idx_n  = tx_state == TX_SEND ? tx_idx + IW'(1) : '0;
        put_n     = tx_next == TX_SEND;
        payload_n = put_n ? head[PKT_W - 1 - int'(tx_idx_n) * PHIT_W -: PHIT_W] : bus.payload_outbound;
    end

    typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;
    rx_state_t               rx_state, rx_next;
    logic [IW-1:0]           rx_cnt, rx_cnt_n;
    logic [PKT_W-PHIT_W-1:0] rx_sh, rx_sh_n;
    logic [PKT_W-1:0]        rx_cat, pkt_out_n;
    logic                    rx_last, rx_abort, free_n;
    assign rx_cat   = {rx_sh, bus.payload_inbound};
    assign rx_last  = rx_state == RX_RECV && bus.put_inbound && rx_cnt == IW'(NPHITS - 1);
    assign rx_abort = rx_state == RX_RECV && !bus.put_inbound;

    always_ff @(posedge clk or negedge rst_b)
        if (!rst_b) begin
            rx_state          <= RX_IDLE;
            rx_cnt            <= '0;
            rx_sh             <= '0;
            bus.free_inbound  <= 1'b0;
            bus.pkt_out       <= '0;
            bus.pkt_out_avail <= 1'b0;
        end else begin
            rx_state          <= rx_next;
            rx_cnt            <= rx_cnt_n;
            rx_sh             <= rx_sh_n;
            bus.free_inbound  <= free_n;
            bus.pkt_out       <= pkt_out_n;
            bus.pkt_out_avail <= rx_last;
        end

    always_comb
        rx_next = (!bus.put_inbound || rx_last) ? RX_IDLE : RX_RECV;

    always_comb begin
        rx_cnt_n  = rx_state == RX_IDLE ? IW'(1) : rx_cnt + IW'(1);
        rx_sh_n   = bus.put_inbound ? rx_cat[PKT_W-PHIT_W-1:0] : rx_sh;
        pkt_out_n = rx_last ? rx_cat : bus.pkt_out;
        free_n    = rx_next == RX_IDLE;
    end

`ifdef NODE_STATS_EN
    logic [1:0] drop_inc;
    assign drop_inc = 2'(bus.pkt_in_avail && bus.cQ_full) + 2'(rx_abort);

    always_ff @(posedge clk or negedge rst_b)
        if (!rst_b) begin
            tx_pkt_cnt <= '0;
            rx_pkt_cnt <= '0;
            drop_cnt   <= '0;
        end else begin
            if (pop && tx_pkt_cnt != 16'hFFFF) tx_pkt_cnt <= tx_pkt_cnt + 16'd1;
            if (rx_last && rx_pkt_cnt != 16'hFFFF) rx_pkt_cnt <= rx_pkt_cnt + 16'd1;
            drop_cnt <= (17'(drop_cnt) + 17'(drop_inc) > 17'hFFFF) ? 16'hFFFF : drop_cnt + 16'(drop_inc);
        end
`endif
endmodule
